// File: rtl/periph_reg_arb.sv
// Round-robin arbiter that shares the peripheral register bus between NUM_REQ requesters.
// It holds each access until the slave acks, or returns ERR_DATA with an error pulse on timeout.
module periph_reg_arb #(
  parameter int          NUM_REQ   = 2,
  parameter int          TO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                   app_clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_cs,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ*9-1:0]   req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ*4-1:0]   req_be,
  output logic [31:0]            req_rdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_err,
  output logic                   reg_cs,
  output logic                   reg_wr,
  output logic [8:0]             reg_addr,
  output logic [31:0]            reg_wdata,
  output logic [3:0]             reg_be,
  input  logic [31:0]            reg_rdata,
  input  logic                   reg_ack,
  output logic                   arb_busy,
  output logic [1:0]             arb_gnt_id
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  localparam logic [1:0] LAST_ID = 2'(NUM_REQ - 1);

  state_t state, state_d;
  logic [1:0]  rr_ptr, rr_ptr_d;
  logic [7:0]  to_cnt, to_cnt_d;

  logic               win_found;
  logic [1:0]         win_id;
  logic               win_wr;
  logic [8:0]         win_addr;
  logic [31:0]        win_wdata;
  logic [3:0]         win_be;
  logic [NUM_REQ-1:0] gnt_onehot;

  logic               reg_cs_d, reg_wr_d, arb_busy_d;
  logic [8:0]         reg_addr_d;
  logic [31:0]        reg_wdata_d, req_rdata_d;
  logic [3:0]         reg_be_d;
  logic [NUM_REQ-1:0] req_ack_d, req_err_d;
  logic [1:0]         arb_gnt_id_d;

  // Two passes give round-robin order: first requesters at or above rr_ptr, then wrap to 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_cs[j] && (2'(j) >= rr_ptr)) begin
        win_found = 1'b1;
        win_id    = 2'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!win_found && req_cs[j]) begin
        win_found = 1'b1;
        win_id    = 2'(j);
      end
    end
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (2'(j) == win_id) begin
        win_wr    = req_wr[j];
        win_addr  = req_addr[9*j +: 9];
        win_wdata = req_wdata[32*j +: 32];
        win_be    = req_be[4*j +: 4];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt_onehot[j] = (2'(j) == arb_gnt_id);
    end
  end

  always_comb begin
    state_d      = state;
    rr_ptr_d     = rr_ptr;
    to_cnt_d     = to_cnt;
    reg_cs_d     = reg_cs;
    reg_wr_d     = reg_wr;
    reg_addr_d   = reg_addr;
    reg_wdata_d  = reg_wdata;
    reg_be_d     = reg_be;
    req_rdata_d  = req_rdata;
    req_ack_d    = '0;
    req_err_d    = '0;
    arb_gnt_id_d = arb_gnt_id;
    unique case (state)
      IDLE: begin
        if (win_found) begin
          reg_cs_d     = 1'b1;
          reg_wr_d     = win_wr;
          reg_addr_d   = win_addr;
          reg_wdata_d  = win_wdata;
          reg_be_d     = win_be;
          arb_gnt_id_d = win_id;
          to_cnt_d     = '0;
          state_d      = GRANT;
        end
      end
      GRANT: begin
        // An ack arriving on the expiry cycle still counts as a normal completion.
        if (reg_ack) begin
          reg_cs_d    = 1'b0;
          req_rdata_d = reg_wr ? '0 : reg_rdata;
          req_ack_d   = gnt_onehot;
          state_d     = RESP;
        end else if (to_cnt == TO_LAST) begin
          reg_cs_d    = 1'b0;
          req_rdata_d = ERR_DATA;
          req_ack_d   = gnt_onehot;
          req_err_d   = gnt_onehot;
          state_d     = RESP;
        end else begin
          to_cnt_d = to_cnt + 8'd1;
        end
      end
      RESP: begin
        rr_ptr_d = (arb_gnt_id == LAST_ID) ? 2'd0 : arb_gnt_id + 2'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    arb_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge app_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      to_cnt     <= '0;
      reg_cs     <= 1'b0;
      reg_wr     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      reg_be     <= '0;
      req_rdata  <= '0;
      req_ack    <= '0;
      req_err    <= '0;
      arb_busy   <= 1'b0;
      arb_gnt_id <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      to_cnt     <= to_cnt_d;
      reg_cs     <= reg_cs_d;
      reg_wr     <= reg_wr_d;
      reg_addr   <= reg_addr_d;
      reg_wdata  <= reg_wdata_d;
      reg_be     <= reg_be_d;
      req_rdata  <= req_rdata_d;
      req_ack    <= req_ack_d;
      req_err    <= req_err_d;
      arb_busy   <= arb_busy_d;
      arb_gnt_id <= arb_gnt_id_d;
    end
  end

endmodule

// File: tb/tb_periph_reg_arb.sv
// Directed bench for periph_reg_arb: two requesters, 8-cycle timeout.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_periph_reg_arb;

  localparam int NUM_REQ   = 2;
  localparam int TO_CYCLES = 8;

  logic        app_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_cs;
  logic [1:0]  req_wr;
  logic [17:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_be;
  logic [31:0] req_rdata;
  logic [1:0]  req_ack;
  logic [1:0]  req_err;
  logic        reg_cs;
  logic        reg_wr;
  logic [8:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic        arb_busy;
  logic [1:0]  arb_gnt_id;

  int total = 0;
  int bad   = 0;

  periph_reg_arb #(
    .NUM_REQ  (NUM_REQ),
    .TO_CYCLES(TO_CYCLES),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .app_clk   (app_clk),
    .reset_n   (reset_n),
    .req_cs    (req_cs),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .req_rdata (req_rdata),
    .req_ack   (req_ack),
    .req_err   (req_err),
    .reg_cs    (reg_cs),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .arb_busy  (arb_busy),
    .arb_gnt_id(arb_gnt_id)
  );

  always #5 app_clk = ~app_clk;

  task automatic tick;
    @(negedge app_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] cs, input logic ack, input logic [31:0] rdata);
    req_cs    = cs;
    reg_ack   = ack;
    reg_rdata = rdata;
  endtask

  // One read with ack latency 1, entered and left on an IDLE falling edge.
  task automatic run_read(input logic [1:0] cs, input logic [1:0] exp_id,
                          input logic [31:0] data, input string tag);
    applyStimulus(cs, 1'b0, 32'h0);
    tick;
    checkOutput({tag, "_cs"}, 32'(reg_cs), 32'd1);
    checkOutput({tag, "_gnt"}, 32'(arb_gnt_id), 32'(exp_id));
    checkOutput({tag, "_noack"}, 32'(req_ack), 32'd0);
    applyStimulus(cs, 1'b1, data);
    tick;
    applyStimulus(cs & ~(2'b01 << exp_id), 1'b0, 32'h0);
    checkOutput({tag, "_ack"}, 32'(req_ack), 32'd1 << exp_id);
    checkOutput({tag, "_err"}, 32'(req_err), 32'd0);
    checkOutput({tag, "_rd"}, req_rdata, data);
    tick;
  endtask

  initial begin
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    applyStimulus(2'b00, 1'b0, 32'h0);
    tick;
    tick;
    checkOutput("rst_cs", 32'(reg_cs), 32'd0);
    checkOutput("rst_ack", 32'(req_ack), 32'd0);
    checkOutput("rst_busy", 32'(arb_busy), 32'd0);
    checkOutput("rst_gnt", 32'(arb_gnt_id), 32'd0);
    checkOutput("rst_rd", req_rdata, 32'd0);
    reset_n = 1'b1;
    tick;

    // T1: single read, slave acks two cycles after reg_cs
    req_addr[8:0] = 9'h040;
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick;
    checkOutput("t1_cs", 32'(reg_cs), 32'd1);
    checkOutput("t1_addr", 32'(reg_addr), 32'h040);
    checkOutput("t1_wr", 32'(reg_wr), 32'd0);
    checkOutput("t1_busy", 32'(arb_busy), 32'd1);
    tick;
    checkOutput("t1_early", 32'(req_ack), 32'd0);
    applyStimulus(2'b01, 1'b1, 32'hCAFE_0001);
    tick;
    applyStimulus(2'b00, 1'b0, 32'h0);
    checkOutput("t1_ack", 32'(req_ack), 32'b01);
    checkOutput("t1_err", 32'(req_err), 32'd0);
    checkOutput("t1_rd", req_rdata, 32'hCAFE_0001);
    checkOutput("t1_csdrop", 32'(reg_cs), 32'd0);
    tick;
    checkOutput("t1_ackpulse", 32'(req_ack), 32'd0);
    checkOutput("t1_idle", 32'(arb_busy), 32'd0);
    checkOutput("t1_hold", req_rdata, 32'hCAFE_0001);

    // T2: both requesting from reset, grants must alternate
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_read(2'b11, 2'(i % 2), 32'hA000_0000 + i, $sformatf("t2_%0d", i));
    end
    applyStimulus(2'b00, 1'b0, 32'h0);

    // T3: slave never acks, timeout after 8 GRANT cycles
    applyStimulus(2'b01, 1'b0, 32'h0);
    tick;
    for (int k = 0; k < 7; k++) tick;
    checkOutput("t3_cs_last", 32'(reg_cs), 32'd1);
    checkOutput("t3_noack", 32'(req_ack), 32'd0);
    tick;
    applyStimulus(2'b00, 1'b0, 32'h0);
    checkOutput("t3_cs", 32'(reg_cs), 32'd0);
    checkOutput("t3_ack", 32'(req_ack), 32'b01);
    checkOutput("t3_err", 32'(req_err), 32'b01);
    checkOutput("t3_rd", req_rdata, 32'hDEAD_BEEF);
    tick;
    checkOutput("t3_errpulse", 32'(req_err), 32'd0);
    checkOutput("t3_idle", 32'(arb_busy), 32'd0);

    // T4: ack on the same cycle the counter expires
    applyStimulus(2'b10, 1'b0, 32'h0);
    tick;
    for (int k = 0; k < 7; k++) tick;
    checkOutput("t4_cs_last", 32'(reg_cs), 32'd1);
    applyStimulus(2'b10, 1'b1, 32'h3141_5926);
    tick;
    applyStimulus(2'b00, 1'b0, 32'h0);
    checkOutput("t4_ack", 32'(req_ack), 32'b10);
    checkOutput("t4_err", 32'(req_err), 32'd0);
    checkOutput("t4_rd", req_rdata, 32'h3141_5926);
    tick;

    // T5: write from requester 1, which drops req_cs during GRANT
    req_addr[17:9]   = 9'h1A4;
    req_wr           = 2'b10;
    req_wdata[63:32] = 32'h1234_5678;
    req_be[7:4]      = 4'h3;
    applyStimulus(2'b10, 1'b0, 32'h0);
    tick;
    checkOutput("t5_gnt", 32'(arb_gnt_id), 32'd1);
    checkOutput("t5_wr", 32'(reg_wr), 32'd1);
    checkOutput("t5_addr", 32'(reg_addr), 32'h1A4);
    checkOutput("t5_wdata", reg_wdata, 32'h1234_5678);
    checkOutput("t5_be", 32'(reg_be), 32'h3);
    applyStimulus(2'b00, 1'b0, 32'h0);
    tick;
    checkOutput("t5_cs_hold", 32'(reg_cs), 32'd1);
    checkOutput("t5_wdata_hold", reg_wdata, 32'h1234_5678);
    checkOutput("t5_addr_hold", 32'(reg_addr), 32'h1A4);
    applyStimulus(2'b00, 1'b1, 32'hFFFF_FFFF);
    tick;
    applyStimulus(2'b00, 1'b0, 32'h0);
    checkOutput("t5_ack", 32'(req_ack), 32'b10);
    checkOutput("t5_rd", req_rdata, 32'd0);
    tick;
    req_wr = 2'b00;

    // T6: reset while in GRANT clears outputs and rr_ptr
    run_read(2'b01, 2'd0, 32'h5555_AAAA, "t6a");
    applyStimulus(2'b10, 1'b0, 32'h0);
    tick;
    checkOutput("t6_gnt1", 32'(arb_gnt_id), 32'd1);
    checkOutput("t6_cs1", 32'(reg_cs), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_cs", 32'(reg_cs), 32'd0);
    checkOutput("t6_rst_busy", 32'(arb_busy), 32'd0);
    checkOutput("t6_rst_gnt", 32'(arb_gnt_id), 32'd0);
    checkOutput("t6_rst_rd", req_rdata, 32'd0);
    checkOutput("t6_rst_addr", 32'(reg_addr), 32'd0);
    tick;
    tick;
    checkOutput("t6_noack", 32'(req_ack), 32'd0);
    reset_n = 1'b1;
    run_read(2'b11, 2'd0, 32'h7777_8888, "t6b");
    applyStimulus(2'b00, 1'b0, 32'h0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
